// File: rtl/ps2_cmd_pkg.sv
// ps2_cmd_pkg
// Shared constants for the PS/2 device-side command responder:
//   - host command bytes (keyboard protocol)
//   - device response bytes
//   - responder FSM state encoding (also exported on the debug port)
package ps2_cmd_pkg;

  // Host-to-device commands
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_RESEND    = 8'hFE;
  localparam logic [7:0] CMD_ECHO      = 8'hEE;
  localparam logic [7:0] CMD_SET_LED   = 8'hED;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] CMD_READ_ID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE    = 8'hF4;
  localparam logic [7:0] CMD_DISABLE   = 8'hF5;
  localparam logic [7:0] CMD_DEFAULT   = 8'hF6;

  // Device-to-host responses
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ECHO   = 8'hEE;

  localparam logic [6:0] TYPEMATIC_DEFAULT = 7'h2B;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_LED = 4'd1,
    ST_WAIT_TYP = 4'd2,
    ST_ID_1     = 4'd3,
    ST_ID_2     = 4'd4,
    ST_BAT      = 4'd5
  } state_t;

  // Argument bytes for ED/F3 have the top bit clear; anything else is a command.
  function automatic logic is_arg_byte(input logic [7:0] b);
    return ~b[7];
  endfunction

endpackage

// File: rtl/ps2_resp_fifo.sv
// ps2_resp_fifo
// Synchronous circular FIFO for response bytes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears contents)
//   push, push_data write request / byte (ignored when full)
//   pop             read request (ignored when empty)
//   head            byte at read pointer
//   empty, full     occupancy flags
//   free            number of unused entries (current, before any same-cycle pop)
module ps2_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign free    = DEPTH_CNT - count;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_cmd_responder.sv
// ps2_cmd_responder
// Device-side PS/2 keyboard command interpreter. Decodes host command bytes,
// keeps LED / typematic / scanning state and queues response bytes in a FIFO
// presented on a valid/ready port.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   received_cmd(_en)           byte from the command receiver, one per strobe cycle
//   resp_data/valid/ready       FIFO head towards the transmitter (pop on valid&ready)
//   led_state, typematic        settings loaded by ED / F3 arguments
//   scanning_en                 key scanning enable
//   cmd_dropped                 one-cycle pulse when a byte is discarded
//   debug                       current FSM state
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for a command byte
// ST_WAIT_LED | ED acknowledged, waiting for the LED argument
// ST_WAIT_TYP | F3 acknowledged, waiting for the typematic argument
// ST_ID_1     | F2 acknowledged, pushing first ID byte
// ST_ID_2     | pushing second ID byte
// ST_BAT      | FF acknowledged, timing out the self-test before AA
module ps2_cmd_responder
  import ps2_cmd_pkg::*;
#(
  parameter int         BAT_DELAY  = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ID_BYTE0   = 8'hAB,
  parameter logic [7:0] ID_BYTE1   = 8'h83
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] received_cmd,
  input  logic       received_cmd_en,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [2:0] led_state,
  output logic [6:0] typematic,
  output logic       scanning_en,
  output logic       cmd_dropped,
  output logic [3:0] debug
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(BAT_DELAY + 1);
  localparam logic [FW-1:0] NEED_ONE = FW'(1);
  localparam logic [FW-1:0] NEED_ID  = FW'(3);
  localparam logic [CW-1:0] BAT_INIT = CW'(BAT_DELAY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state, state_n;
  logic [CW-1:0] bat_cnt;
  logic [7:0]    last_sent;

  logic          push;
  logic [7:0]    push_data;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [FW-1:0] fifo_free;

  logic          drop;
  logic          idle_decode;
  logic          bat_load;
  logic [FW-1:0] need;
  logic [2:0]    led_n;
  logic [6:0]    typ_n;
  logic          scan_n;

  assign pop        = resp_valid & resp_ready;
  assign resp_valid = ~fifo_empty;
  assign debug      = state;

  ps2_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (resp_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .free      (fifo_free)
  );

  // Decode of the current byte / state into the FIFO write and next settings.
  always_comb begin
    state_n     = state;
    led_n       = led_state;
    typ_n       = typematic;
    scan_n      = scanning_en;
    push        = 1'b0;
    push_data   = RSP_ACK;
    drop        = 1'b0;
    idle_decode = 1'b0;
    bat_load    = 1'b0;
    need        = NEED_ONE;

    case (state)
      ST_IDLE: begin
        if (received_cmd_en) idle_decode = 1'b1;
      end
      ST_WAIT_LED, ST_WAIT_TYP: begin
        if (received_cmd_en) begin
          if (is_arg_byte(received_cmd)) begin
            if (fifo_free >= NEED_ONE) begin
              if (state == ST_WAIT_LED) led_n = received_cmd[2:0];
              else                      typ_n = received_cmd[6:0];
              push    = 1'b1;
              state_n = ST_IDLE;
            end else begin
              drop = 1'b1;
            end
          end else begin
            // A command byte abandons the argument wait and is decoded now.
            idle_decode = 1'b1;
          end
        end
      end
      ST_ID_1: begin
        push      = 1'b1;
        push_data = ID_BYTE0;
        state_n   = ST_ID_2;
        drop      = received_cmd_en;
      end
      ST_ID_2: begin
        push      = 1'b1;
        push_data = ID_BYTE1;
        state_n   = ST_IDLE;
        drop      = received_cmd_en;
      end
      ST_BAT: begin
        drop = received_cmd_en;
        // Counter at 1 is the terminal cycle; it parks at 0 if the FIFO is full.
        if ((bat_cnt <= CNT_ONE) && !fifo_full) begin
          push      = 1'b1;
          push_data = RSP_BAT_OK;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (idle_decode) begin
      // Read ID reserves room for the ACK plus both ID bytes up front.
      need = (received_cmd == CMD_READ_ID) ? NEED_ID : NEED_ONE;
      if (fifo_free < need) begin
        drop    = 1'b1;
        state_n = state;
      end else begin
        push      = 1'b1;
        push_data = RSP_ACK;
        state_n   = ST_IDLE;
        case (received_cmd)
          CMD_RESET: begin
            led_n    = 3'b000;
            typ_n    = TYPEMATIC_DEFAULT;
            scan_n   = 1'b1;
            bat_load = 1'b1;
            state_n  = ST_BAT;
          end
          CMD_RESEND:    push_data = last_sent;
          CMD_ECHO:      push_data = RSP_ECHO;
          CMD_SET_LED:   state_n   = ST_WAIT_LED;
          CMD_TYPEMATIC: state_n   = ST_WAIT_TYP;
          CMD_READ_ID:   state_n   = ST_ID_1;
          CMD_ENABLE:    scan_n    = 1'b1;
          CMD_DISABLE:   scan_n    = 1'b0;
          CMD_DEFAULT: begin
            typ_n  = TYPEMATIC_DEFAULT;
            scan_n = 1'b1;
          end
          default:       push_data = RSP_RESEND;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      led_state   <= 3'b000;
      typematic   <= TYPEMATIC_DEFAULT;
      scanning_en <= 1'b1;
      cmd_dropped <= 1'b0;
      last_sent   <= RSP_ACK;
      bat_cnt     <= '0;
    end else begin
      state       <= state_n;
      led_state   <= led_n;
      typematic   <= typ_n;
      scanning_en <= scan_n;
      cmd_dropped <= drop;
      if (pop) last_sent <= resp_data;
      if (bat_load)
        bat_cnt <= BAT_INIT;
      else if ((state == ST_BAT) && (bat_cnt != '0))
        bat_cnt <= bat_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_responder.sv
// tb_ps2_cmd_responder
// Directed sequence followed by a randomized phase, all checked each cycle
// against a queue-based behavioural model of the responder.
module tb_ps2_cmd_responder;

  localparam int         BAT_DELAY = 16;
  localparam int         DEPTH     = 4;
  localparam logic [7:0] ID0       = 8'hAB;
  localparam logic [7:0] ID1       = 8'h83;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] received_cmd;
  logic       received_cmd_en;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] led_state;
  logic [6:0] typematic;
  logic       scanning_en;
  logic       cmd_dropped;
  logic [3:0] debug;

  int tests = 0;
  int fails = 0;

  ps2_cmd_responder #(
    .BAT_DELAY  (BAT_DELAY),
    .FIFO_DEPTH (DEPTH),
    .ID_BYTE0   (ID0),
    .ID_BYTE1   (ID1)
  ) dut (
    .clk             (clk),
    .reset           (rst_n),
    .received_cmd    (received_cmd),
    .received_cmd_en (received_cmd_en),
    .resp_data       (resp_data),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .led_state       (led_state),
    .typematic       (typematic),
    .scanning_en     (scanning_en),
    .cmd_dropped     (cmd_dropped),
    .debug           (debug)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 LED arg, 2 typematic arg, 3/4 ID bytes pending, 5 self-test
  int         m_mode;
  logic [7:0] q[$];
  logic [2:0] m_led;
  logic [6:0] m_typ;
  logic       m_scan;
  logic       m_drop;
  logic [7:0] m_last;
  int         cyc = 0;
  int         bat_due = 0;

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_led  = 3'b000;
    m_typ  = 7'h2B;
    m_scan = 1'b1;
    m_drop = 1'b0;
    m_last = 8'hFA;
  endtask

  task automatic model_step(input logic en, input logic [7:0] b, input logic rdy);
    int         free_slots;
    int         need;
    bit         as_cmd;
    logic [7:0] out[$];
    free_slots = DEPTH - q.size();
    m_drop = 1'b0;
    as_cmd = 1'b0;
    case (m_mode)
      0: as_cmd = en;
      1, 2: if (en) begin
        if (b < 8'h80) begin
          if (free_slots >= 1) begin
            if (m_mode == 1) m_led = b[2:0];
            else             m_typ = b[6:0];
            out.push_back(8'hFA);
            m_mode = 0;
          end else m_drop = 1'b1;
        end else as_cmd = 1'b1;
      end
      3: begin out.push_back(ID0); m_mode = 4; m_drop = en; end
      4: begin out.push_back(ID1); m_mode = 0; m_drop = en; end
      5: begin
        m_drop = en;
        if (cyc >= bat_due && q.size() < DEPTH) begin
          out.push_back(8'hAA);
          m_mode = 0;
        end
      end
      default: m_mode = 0;
    endcase
    if (as_cmd) begin
      need = (b == 8'hF2) ? 3 : 1;
      if (free_slots < need) m_drop = 1'b1;
      else begin
        case (b)
          8'hFF: begin
            out.push_back(8'hFA); m_led = 3'b000; m_typ = 7'h2B; m_scan = 1'b1;
            bat_due = cyc + BAT_DELAY; m_mode = 5;
          end
          8'hFE: begin out.push_back(m_last); m_mode = 0; end
          8'hEE: begin out.push_back(8'hEE); m_mode = 0; end
          8'hED: begin out.push_back(8'hFA); m_mode = 1; end
          8'hF3: begin out.push_back(8'hFA); m_mode = 2; end
          8'hF2: begin out.push_back(8'hFA); m_mode = 3; end
          8'hF4: begin out.push_back(8'hFA); m_scan = 1'b1; m_mode = 0; end
          8'hF5: begin out.push_back(8'hFA); m_scan = 1'b0; m_mode = 0; end
          8'hF6: begin out.push_back(8'hFA); m_typ = 7'h2B; m_scan = 1'b1; m_mode = 0; end
          default: begin out.push_back(8'hFE); m_mode = 0; end
        endcase
      end
    end
    if (rdy && q.size() > 0) m_last = q.pop_front();
    foreach (out[i]) q.push_back(out[i]);
    cyc++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(resp_valid), 32'(q.size() != 0));
    if (q.size() != 0) check({tag, ".data"}, 32'(resp_data), 32'(q[0]));
    check({tag, ".led"},  32'(led_state),   32'(m_led));
    check({tag, ".typ"},  32'(typematic),   32'(m_typ));
    check({tag, ".scan"}, 32'(scanning_en), 32'(m_scan));
    check({tag, ".drop"}, 32'(cmd_dropped), 32'(m_drop));
    check({tag, ".state"}, 32'(debug),      32'(m_mode));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".valid"}, 32'(resp_valid),  32'd0);
    check({tag, ".data"},  32'(resp_data),   32'd0);
    check({tag, ".led"},   32'(led_state),   32'd0);
    check({tag, ".typ"},   32'(typematic),   32'h2B);
    check({tag, ".scan"},  32'(scanning_en), 32'd1);
    check({tag, ".drop"},  32'(cmd_dropped), 32'd0);
    check({tag, ".state"}, 32'(debug),       32'd0);
  endtask

  // Drive one cycle's inputs, advance the clock, update the model, compare.
  task automatic cycle(input string tag, input logic en, input logic [7:0] b, input logic rdy);
    received_cmd_en = en;
    received_cmd    = b;
    resp_ready      = rdy;
    @(posedge clk);
    model_step(en, b, rdy);
    #1;
    check_all(tag);
  endtask

  logic [7:0] pool [12];

  initial begin
    int n;
    bit seen;
    pool = '{8'hFF, 8'hFE, 8'hEE, 8'hED, 8'hF3, 8'hF2, 8'hF4, 8'hF5, 8'hF6,
             8'h12, 8'h05, 8'h7F};

    // Reset
    rst_n = 1'b0;
    received_cmd_en = 1'b0;
    received_cmd = 8'h00;
    resp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // ED, 20 cycles later 05
    cycle("led_cmd", 1'b1, 8'hED, 1'b1);
    repeat (19) cycle("led_gap", 1'b0, 8'h00, 1'b1);
    cycle("led_arg", 1'b1, 8'h05, 1'b1);
    repeat (3) cycle("led_tail", 1'b0, 8'h00, 1'b1);
    check("led_value", 32'(led_state), 32'h5);
    check("led_idle", 32'(debug), 32'd0);

    // F2 with ready low, then a second F2 with only one slot free
    cycle("id_cmd", 1'b1, 8'hF2, 1'b0);
    repeat (3) cycle("id_fill", 1'b0, 8'h00, 1'b0);
    cycle("id_again", 1'b1, 8'hF2, 1'b0);
    check("id_drop", 32'(cmd_dropped), 32'd1);
    check("id_head0", 32'(resp_data), 32'hFA);
    cycle("id_pop0", 1'b0, 8'h00, 1'b1);
    check("id_head1", 32'(resp_data), 32'hAB);
    cycle("id_pop1", 1'b0, 8'h00, 1'b1);
    check("id_head2", 32'(resp_data), 32'h83);
    cycle("id_pop2", 1'b0, 8'h00, 1'b1);
    check("id_empty", 32'(resp_valid), 32'd0);

    // F3 7F then FF: self-test restores defaults, AA after BAT_DELAY cycles
    cycle("typ_cmd", 1'b1, 8'hF3, 1'b1);
    cycle("typ_arg", 1'b1, 8'h7F, 1'b1);
    cycle("dis", 1'b1, 8'hF5, 1'b1);
    cycle("bat_cmd", 1'b1, 8'hFF, 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      cycle("bat_wait", (n == 3), 8'hEE, 1'b1);
      n++;
      if (n == 4) check("bat_echo_drop", 32'(cmd_dropped), 32'd1);
      if (resp_valid && resp_data == 8'hAA) seen = 1'b1;
    end
    check("bat_seen", 32'(seen), 32'd1);
    check("bat_delay", 32'(n), 32'(BAT_DELAY));
    check("bat_typ", 32'(typematic), 32'h2B);
    check("bat_scan", 32'(scanning_en), 32'd1);
    repeat (2) cycle("bat_tail", 1'b0, 8'h00, 1'b1);

    // ED 03, F5, then ED followed by F4 instead of an argument
    cycle("led2_cmd", 1'b1, 8'hED, 1'b1);
    cycle("led2_arg", 1'b1, 8'h03, 1'b1);
    cycle("dis2", 1'b1, 8'hF5, 1'b1);
    cycle("abort_ed", 1'b1, 8'hED, 1'b1);
    cycle("abort_f4", 1'b1, 8'hF4, 1'b1);
    repeat (2) cycle("abort_tail", 1'b0, 8'h00, 1'b1);
    check("abort_led", 32'(led_state), 32'h3);
    check("abort_scan", 32'(scanning_en), 32'd1);
    check("abort_state", 32'(debug), 32'd0);

    // Echo, resend of the echo, unknown byte
    cycle("echo", 1'b1, 8'hEE, 1'b1);
    cycle("echo_pop", 1'b0, 8'h00, 1'b1);
    cycle("resend", 1'b1, 8'hFE, 1'b0);
    check("resend_data", 32'(resp_data), 32'hEE);
    cycle("resend_pop", 1'b0, 8'h00, 1'b1);
    cycle("unknown", 1'b1, 8'h12, 1'b0);
    check("unknown_data", 32'(resp_data), 32'hFE);
    cycle("unknown_pop", 1'b0, 8'h00, 1'b1);

    // Fill the FIFO, reset mid-stream
    repeat (4) cycle("fill", 1'b1, 8'hEE, 1'b0);
    check("fill_valid", 32'(resp_valid), 32'd1);
    cycle("fill_full", 1'b1, 8'hEE, 1'b0);
    check("fill_drop", 32'(cmd_dropped), 32'd1);
    received_cmd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("resume", 1'b1, 8'hEE, 1'b1);
    check("resume_data", 32'(resp_data), 32'hEE);
    repeat (2) cycle("resume_tail", 1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic       en;
      logic       rdy;
      logic [7:0] b;
      en  = ($urandom_range(0, 9) < 4);
      rdy = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
      else                           b = pool[$urandom_range(0, 11)];
      cycle("rand", en, b, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
